mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 59 +++++
 rtl/mul_div_unit_step.sv | 60 ++++++
 rtl/mul_div_unit.sv | 186 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - F3_* constants: RISC-V M-extension funct3 encodings, also used by the
//     instruction decoder so both sides agree on the op numbering.
//   - mdu_op_t:    operation enum built on those encodings.
//   - mdu_state_t: sequencing FSM states of mul_div_unit.
//   - small predicates classifying an op (divide, remainder, signedness).
package mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [2:0] {
        OP_MUL    = F3_MUL,
        OP_MULH   = F3_MULH,
        OP_MULHSU = F3_MULHSU,
        OP_MULHU  = F3_MULHU,
        OP_DIV    = F3_DIV,
        OP_DIVU   = F3_DIVU,
        OP_REM    = F3_REM,
        OP_REMU   = F3_REMU
    } mdu_op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } mdu_state_t;

    function automatic logic op_is_div(input mdu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input mdu_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_signed_div(input mdu_op_t op);
        return op inside {OP_DIV, OP_REM};
    endfunction

    // First operand is treated as two's complement.
    function automatic logic op_a_signed(input mdu_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // Second operand is treated as two's complement.
    function automatic logic op_b_signed(input mdu_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// mdu_step: one combinational iteration on the {hi, lo} working pair.
//   Multiply: radix-2 shift-add. If lo[0] is set, m is added into hi; the
//             (WIDTH+1)-bit sum and lo are shifted right one place together.
//   Divide:   restoring shift-subtract. {hi, lo[MSB]} is compared against m;
//             on success the difference becomes the new partial remainder.
//             The quotient bit enters lo from the right.
// Ports:
//   is_div          - 1 selects the divide step, 0 the multiply step
//   hi, lo          - current working pair (partial product / remainder:quotient)
//   m               - multiplicand or divisor magnitude
//   hi_next, lo_next- working pair after this iteration
module mdu_step #(
    parameter int WIDTH = 64
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] base;
    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;
    logic           cin;
    logic           fits;

    always_comb begin
        base    = {1'b0, hi};
        addend  = '0;
        cin     = 1'b0;
        hi_next = hi;
        lo_next = lo;
        fits    = 1'b0;

        if (is_div) begin
            // Subtract via the same adder: base + ~m + 1.
            base   = {hi, lo[WIDTH-1]};
            addend = ~{1'b0, m};
            cin    = 1'b1;
        end else if (lo[0]) begin
            addend = {1'b0, m};
        end

        sum = base + addend + {{WIDTH{1'b0}}, cin};

        if (is_div) begin
            // The partial remainder is always below m, so the shifted value
            // is below 2*m: a set top bit can only mean the subtract borrowed.
            fits    = ~sum[WIDTH];
            hi_next = fits ? sum[WIDTH-1:0] : base[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], fits};
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RISC-V M-extension multiply/divide unit.
// One operation at a time: IDLE -> PREP -> CALC (WIDTH cycles) -> FIX -> DONE.
// Divide-by-zero and signed overflow short-cut PREP -> DONE.
// Handshake: start is taken only while busy is low (IDLE or DONE); op/a/b are
// sampled on that edge. done is a one-cycle pulse; result is valid from that
// cycle and held until the next operation finishes. flush (while busy) drops
// the operation without a done pulse and without touching result.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start, op     - request and funct3-encoded operation
//   a, b          - operands (multiplicand/dividend, multiplier/divisor)
//   flush         - abort the in-flight operation
//   busy, done    - in-flight flag, completion pulse
//   result        - operation result
//   div_zero      - with done: a divide/remainder had b == 0
//   fsm_state     - current FSM state, for observation
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero,
    output mdu_state_t       fsm_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_t       state_q, state_d;
    mdu_op_t          op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi_q, lo_q, m_q;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             dz_q;

    // Operand preparation, evaluated from the captured request.
    logic             is_div, is_rem;
    logic             neg_a, neg_b, res_neg;
    logic             b_zero, ovf;
    logic [WIDTH-1:0] mag_a, mag_b, special_value;

    always_comb begin
        is_div  = op_is_div(op_q);
        is_rem  = op_is_rem(op_q);
        neg_a   = op_a_signed(op_q) & a_q[WIDTH-1];
        neg_b   = op_b_signed(op_q) & b_q[WIDTH-1];
        mag_a   = neg_a ? -a_q : a_q;
        mag_b   = neg_b ? -b_q : b_q;
        b_zero  = is_div && (b_q == '0);
        ovf     = op_is_signed_div(op_q) && (a_q == MOST_NEG) && (b_q == '1);
        // Remainder follows the dividend; products and quotients the XOR.
        res_neg = is_rem ? neg_a : (neg_a ^ neg_b);
        if (b_zero) begin
            special_value = is_rem ? a_q : '1;
        end else begin
            special_value = is_rem ? '0 : a_q;
        end
    end

    // Sign correction and half selection for the FIX state.
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   div_sel, fix_value;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        div_sel  = is_rem ? hi_q : lo_q;
        if (is_div) begin
            fix_value = neg_q ? -div_sel : div_sel;
        end else if (op_q == OP_MUL) begin
            fix_value = prod_fix[WIDTH-1:0];
        end else begin
            fix_value = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    logic [WIDTH-1:0] step_hi, step_lo;

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div  (is_div),
        .hi      (hi_q),
        .lo      (lo_q),
        .m       (m_q),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: state_d = start ? S_PREP : S_IDLE;
            S_PREP: begin
                busy    = 1'b1;
                state_d = (b_zero || ovf) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                // Last iteration: the counter is about to reach zero.
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush && busy) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q <= mdu_op_t'(op);
                        a_q  <= a;
                        b_q  <= b;
                    end
                end
                S_PREP: begin
                    if (!flush) begin
                        if (b_zero || ovf) begin
                            result_q <= special_value;
                            dz_q     <= b_zero;
                        end else begin
                            hi_q  <= '0;
                            lo_q  <= is_div ? mag_a : mag_b;
                            m_q   <= is_div ? mag_b : mag_a;
                            cnt_q <= CW'(WIDTH);
                            neg_q <= res_neg;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        hi_q  <= step_hi;
                        lo_q  <= step_lo;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        result_q <= fix_value;
                        dz_q     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done      = (state_q == S_DONE);
    assign div_zero  = done & dz_q;
    assign result    = result_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: one WIDTH=64 and one WIDTH=8 instance on a shared
// clock/reset. Drivers push expected responses from an arithmetic reference
// model; per-instance monitors pop and compare whenever done is seen.
module tb_mul_div_unit;
    import mdu_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // WIDTH = 64 instance
    logic        start64 = 1'b0, flush64 = 1'b0;
    logic [2:0]  op64 = '0;
    logic [63:0] a64 = '0, b64 = '0;
    logic        busy64, done64, dz64;
    logic [63:0] result64;
    mdu_state_t  st64;

    // WIDTH = 8 instance
    logic        start8 = 1'b0, flush8 = 1'b0;
    logic [2:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  result8;
    mdu_state_t  st8;

    exp_t        exp64_q[$];
    exp_t        exp8_q[$];
    logic [63:0] last64 = '0;

    mul_div_unit #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .start(start64), .op(op64), .a(a64), .b(b64),
        .flush(flush64), .busy(busy64), .done(done64), .result(result64),
        .div_zero(dz64), .fsm_state(st64)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(flush8), .busy(busy8), .done(done8), .result(result8),
        .div_zero(dz8), .fsm_state(st8)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [63:0] mask_of(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    // Returns {div_zero, result} for a w-bit unit, using wide integer arithmetic.
    function automatic logic [64:0] model(input int w, input logic [2:0] o,
                                          input logic [63:0] x, input logic [63:0] y);
        logic [63:0]         mask, xm, ym, r;
        logic [127:0]        ux, uy, up;
        logic signed [127:0] sx, sy, tmp, one, most_neg;
        logic                dz;
        mask = mask_of(w);
        xm = x & mask;
        ym = y & mask;
        ux = {64'd0, xm};
        uy = {64'd0, ym};
        one = 128'sd1;
        sx = $signed(ux);
        sy = $signed(uy);
        if (xm[w-1]) sx = sx - (one <<< w);
        if (ym[w-1]) sy = sy - (one <<< w);
        most_neg = -(one <<< (w - 1));
        dz = 1'b0;
        r = '0;
        case (o)
            3'd0: begin up = ux * uy; r = up[63:0]; end
            3'd1: begin tmp = (sx * sy) >>> w; r = tmp[63:0]; end
            3'd2: begin tmp = (sx * $signed(uy)) >>> w; r = tmp[63:0]; end
            3'd3: begin up = (ux * uy) >> w; r = up[63:0]; end
            3'd4: begin
                if (ym == 0) begin r = mask; dz = 1'b1; end
                else if (sx == most_neg && sy == -1) r = xm;
                else begin tmp = sx / sy; r = tmp[63:0]; end
            end
            3'd5: begin
                if (ym == 0) begin r = mask; dz = 1'b1; end
                else begin up = ux / uy; r = up[63:0]; end
            end
            3'd6: begin
                if (ym == 0) begin r = xm; dz = 1'b1; end
                else if (sx == most_neg && sy == -1) r = '0;
                else begin tmp = sx % sy; r = tmp[63:0]; end
            end
            default: begin
                if (ym == 0) begin r = xm; dz = 1'b1; end
                else begin up = ux % uy; r = up[63:0]; end
            end
        endcase
        return {dz, r & mask};
    endfunction

    // Cycles from the cycle start is driven to the cycle done is seen.
    function automatic int latency(input int w, input logic [2:0] o,
                                   input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mask;
        mask = mask_of(w);
        if (o[2] && (y & mask) == 0) return 2;
        if ((o == 3'd4 || o == 3'd6) && (x & mask) == (64'd1 << (w - 1)) && (y & mask) == mask)
            return 2;
        return w + 3;
    endfunction

    function automatic logic [63:0] pick(input int w);
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return {64{1'b1}};
            2: return 64'd1 << (w - 1);
            3: return 64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    // Waits for the selected unit to be free, presents one request for one
    // cycle and (optionally) queues the expected response.
    task automatic issue(input int which, input logic [2:0] o, input logic [63:0] x,
                         input logic [63:0] y, input bit expect_it);
        exp_t        e;
        logic [64:0] m;
        int          guard;
        int          w;
        w = (which == 64) ? 64 : 8;
        @(posedge clk);
        #1;
        guard = 0;
        while (((which == 64) ? busy64 : busy8) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) check($sformatf("wait_free_%0d", which), 64'd1, 64'd0);
        m     = model(w, o, x, y);
        e.res = m[63:0];
        e.dz  = m[64];
        e.due = cyc + latency(w, o, x, y);
        if (which == 64) begin
            op64 = o; a64 = x; b64 = y; start64 = 1'b1;
            if (expect_it) exp64_q.push_back(e);
        end else begin
            op8 = o; a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1;
            if (expect_it) exp8_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (which == 64) begin
            start64 = 1'b0;
            check("busy64_after_start", 64'(busy64), 64'd1);
        end else begin
            start8 = 1'b0;
            check("busy8_after_start", 64'(busy8), 64'd1);
        end
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (done64) begin
                if (exp64_q.size() == 0) begin
                    check("done64_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp64_q.pop_front();
                    check("result64", result64, e.res);
                    check("div_zero64", 64'(dz64), 64'(e.dz));
                    check("latency64", 64'(cyc), 64'(e.due));
                    last64 = e.res;
                end
            end else begin
                check("div_zero64_without_done", 64'(dz64), 64'd0);
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (done8) begin
                if (exp8_q.size() == 0) begin
                    check("done8_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp8_q.pop_front();
                    check("result8", 64'(result8), e.res);
                    check("div_zero8", 64'(dz8), 64'(e.dz));
                    check("latency8", 64'(cyc), 64'(e.due));
                end
            end else begin
                check("div_zero8_without_done", 64'(dz8), 64'd0);
            end
        end
    end

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp64_q.size() != 0 || exp8_q.size() != 0) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_pending", 64'(exp64_q.size() + exp8_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_busy64", 64'(busy64), 64'd0);
        check("rst_done64", 64'(done64), 64'd0);
        check("rst_dz64", 64'(dz64), 64'd0);
        check("rst_result64", result64, 64'd0);
        check("rst_state64", 64'(st64), 64'(S_IDLE));
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_dz8", 64'(dz8), 64'd0);
        check("rst_result8", 64'(result8), 64'd0);
        check("rst_state8", 64'(st8), 64'(S_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Directed cases, WIDTH = 64.
        issue(64, 3'd0, 64'd7, -64'd3, 1);
        issue(64, 3'd3, {64{1'b1}}, {64{1'b1}}, 1);
        issue(64, 3'd1, {64{1'b1}}, {64{1'b1}}, 1);
        issue(64, 3'd4, -64'd7, 64'd2, 1);
        issue(64, 3'd6, -64'd7, 64'd2, 1);
        issue(64, 3'd5, 64'd7, 64'd0, 1);
        issue(64, 3'd4, 64'h8000_0000_0000_0000, {64{1'b1}}, 1);
        issue(64, 3'd6, 64'h8000_0000_0000_0000, {64{1'b1}}, 1);
        issue(64, 3'd2, -64'd5, 64'd3, 1);
        drain();

        // Flush during the tenth CALC cycle: no done, result retained.
        issue(64, 3'd0, 64'd12345, 64'd678, 0);
        repeat (10) @(posedge clk);
        #1;
        check("flush_in_calc_state", 64'(st64), 64'(S_CALC));
        flush64 = 1'b1;
        @(posedge clk);
        #1;
        flush64 = 1'b0;
        check("flush_busy64", 64'(busy64), 64'd0);
        check("flush_result64", result64, last64);
        repeat (80) @(posedge clk);
        #1;
        check("flush_result64_later", result64, last64);
        issue(64, 3'd4, 64'd1000, 64'd7, 1);
        drain();

        // Directed cases, WIDTH = 8, with a start pulse while busy.
        issue(8, 3'd7, 64'd200, 64'd7, 1);
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1; op8 = 3'd0; a8 = 8'd3; b8 = 8'd5;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        issue(8, 3'd4, 64'h80, 64'hFF, 1);
        issue(8, 3'd6, 64'hF9, 64'd2, 1);
        drain();

        // Randomized traffic on both units concurrently.
        fork
            begin
                for (int i = 0; i < 30; i++)
                    issue(64, 3'($urandom_range(0, 7)), pick(64), pick(64), 1);
            end
            begin
                for (int j = 0; j < 150; j++)
                    issue(8, 3'($urandom_range(0, 7)), pick(8), pick(8), 1);
            end
        join
        drain();

        // Reset in the middle of an operation: abort, no done pulse.
        issue(8, 3'd4, 64'd100, 64'd7, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        issue(8, 3'd5, 64'd100, 64'd7, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
